sd_cmd_framer: RTL
==================

# sd_cmd_framer

SPI-mode SD command framer that sits directly upstream of the microSD byte shifter. Builds the 6-byte command frame (start bits, index, 32-bit argument, CRC7, end bit) and feeds it byte-by-byte over the shifter's W_STB/W_DATA port. Then polls the card with 0xFF fill bytes over R_STB/R_DATA until an R1 response arrives or the poll limit expires. Used by the card-init and block-access sequencers to issue single commands.

## Interface
- TIMEOUT_BYTES, 8: maximum number of poll bytes (Ncr) before declaring timeout; legal range 1..255.
- CLK50  in  1  system clock, 50 MHz, all logic on rising edge.
- RST_N  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- CMD_START  in  1  one-cycle request; accepted only when BUSY=0.
- CMD_INDEX  in  6  command index, latched on the accepted CMD_START.
- CMD_ARG  in  32  command argument, latched on the accepted CMD_START.
- BUSY  out  1  high from the cycle after acceptance until the DONE cycle, inclusive.
- DONE  out  1  one-cycle pulse: command finished (response or timeout).
- TIMEOUT  out  1  one-cycle pulse coincident with DONE when no R1 was received.
- RESP  out  8  last R1 byte; 0xFF after a timeout; held until the next DONE.
- W_STB  out  1  one-cycle byte-write strobe to the shifter.
- W_DATA  out  8  byte to shift; valid whenever W_STB=1.
- BYTE_DONE  in  1  one-cycle pulse from the shifter: the last written byte is fully shifted (and the received byte is available).
- R_STB  out  1  one-cycle read strobe to the shifter.
- R_DATA  in  8  received byte; sampled the cycle after R_STB.

## Operation
- Frame bits: {2'b01, CMD_INDEX, CMD_ARG} = 40 bits, MSB first. Byte 6 is {CRC7, 1'b1}.
- CRC7: polynomial x^7+x^3+1, init 0, computed serially one bit per clock over the 40 bits.
- States:
  - IDLE: waits for CMD_START.
  - CRC: 40 cycles.
  - TX: assert W_STB with byte n.
  - TX_WAIT: wait for BYTE_DONE. n goes 0..5, then POLL.
  - POLL: W_STB with 0xFF.
  - POLL_WAIT: wait for BYTE_DONE.
  - RD: assert R_STB.
  - SAMPLE: capture R_DATA.
  - FIN: DONE pulse, return to IDLE.
- SAMPLE transitions:
  - R_DATA[7]=0: RESP<=R_DATA, go to FIN with TIMEOUT=0.
  - Otherwise, increment the 8-bit poll counter. If it reaches TIMEOUT_BYTES: RESP<=0xFF, FIN with TIMEOUT=1. Else go back to POLL.
- The poll counter and byte index clear on acceptance.
- Boundary behaviour:
  - CMD_START while BUSY=1 is ignored; no queuing.
  - BYTE_DONE outside the TX_WAIT and POLL_WAIT states is ignored.
  - CMD_INDEX and CMD_ARG changes after acceptance have no effect.
  - RST_N low at any point: immediate return to IDLE. The shifter sees no further strobes; a partial frame is abandoned.
  - Reset values: W_STB=0, R_STB=0, W_DATA=0xFF, BUSY=0, DONE=0, TIMEOUT=0, RESP=0xFF. Counters and CRC are 0.

## Timing
- CMD_START accepted at edge k: BUSY=1 from k+1. CRC occupies k+1..k+40. First W_STB at k+41.
- Each W_STB is exactly 1 cycle. The next W_STB comes no earlier than 1 cycle after the BYTE_DONE that closes the previous byte. BYTE_DONE in the same cycle as W_STB is not counted for that byte.
- Poll byte sequence: BYTE_DONE at edge t, R_STB=1 at t+1, R_DATA sampled at t+2.
  - Next poll W_STB at t+3.
  - On a response, DONE=1 at t+3. RESP is valid from t+3.
- FIN cycle: BUSY=1, DONE=1. IDLE follows. A CMD_START in the FIN cycle is ignored; the earliest accepted start is the cycle after DONE.
- Latency, excluding shifter time: 40 + 6 x (2 + shift) + p x (4 + shift) + 1 cycles, where p is the number of poll bytes.

## Test plan
- CMD0, ARG=0x00000000, BYTE_DONE model at 16 cycles/byte, R_DATA=0x01 on first poll -> W_DATA sequence 40 00 00 00 00 95, one poll, RESP=0x01, DONE=1, TIMEOUT=0.
- CMD8, ARG=0x000001AA, responses FF, FF, 01 -> W_DATA 48 00 00 01 AA 87, three 0xFF polls, RESP=0x01.
- CMD55, ARG=0, R_DATA constantly 0xFF -> exactly 8 polls, DONE and TIMEOUT pulse together, RESP=0xFF, BUSY drops the next cycle.
- CMD_START pulsed during TX and in the FIN cycle -> both ignored, no extra W_STB; a start one cycle after DONE is accepted.
- RST_N low during the 4th frame byte -> all outputs at reset values asynchronously. After release, a new CMD0 produces a complete 40 00 00 00 00 95 frame.
- Spurious BYTE_DONE pulses during the CRC state -> frame and timing unchanged.

Source files
------------

// File: rtl/sd_cmd_framer.sv
// ============================================================================
// Module : sd_cmd_framer
// Builds a 6-byte SPI-mode SD command (with serial CRC7), pushes it to the
// byte shifter, then polls with 0xFF fill bytes for an R1 response.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sd_cmd_framer #(
  parameter int TIMEOUT_BYTES = 8
) (
  input  logic        CLK50,
  input  logic        RST_N,
  input  logic        CMD_START,
  input  logic [5:0]  CMD_INDEX,
  input  logic [31:0] CMD_ARG,
  output logic        BUSY,
  output logic        DONE,
  output logic        TIMEOUT,
  output logic [7:0]  RESP,
  output logic        W_STB,
  output logic [7:0]  W_DATA,
  input  logic        BYTE_DONE,
  output logic        R_STB,
  input  logic [7:0]  R_DATA
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_CRC       = 4'd1;
  localparam logic [3:0] S_TX        = 4'd2;
  localparam logic [3:0] S_TX_WAIT   = 4'd3;
  localparam logic [3:0] S_POLL      = 4'd4;
  localparam logic [3:0] S_POLL_WAIT = 4'd5;
  localparam logic [3:0] S_RD        = 4'd6;
  localparam logic [3:0] S_SAMPLE    = 4'd7;
  localparam logic [3:0] S_FIN       = 4'd8;

  localparam logic [7:0] C_TIMEOUT   = 8'(TIMEOUT_BYTES);
  localparam logic [6:0] C_CRC_POLY  = 7'h09;

  logic [3:0]  r_state;
  logic [3:0]  w_state_next;
  logic [39:0] r_frame;
  logic [6:0]  r_crc;
  logic [5:0]  r_bit_cnt;
  logic [2:0]  r_byte_idx;
  logic [7:0]  r_poll_cnt;
  logic [7:0]  r_resp;
  logic        r_timeout;

  logic [5:0]  w_bit_idx;
  logic        w_crc_fb;
  logic [7:0]  w_poll_inc;
  logic        w_resp_hit;
  logic        w_poll_expired;
  logic [7:0]  w_tx_byte;

  assign w_bit_idx      = 6'd39 - r_bit_cnt;
  assign w_crc_fb       = r_frame[w_bit_idx] ^ r_crc[6];
  assign w_poll_inc     = r_poll_cnt + 8'd1;
  assign w_resp_hit     = ~R_DATA[7];
  assign w_poll_expired = (w_poll_inc == C_TIMEOUT);

  always_comb begin
    w_tx_byte = 8'hFF;
    case (r_byte_idx)
      3'd0:    w_tx_byte = r_frame[39:32];
      3'd1:    w_tx_byte = r_frame[31:24];
      3'd2:    w_tx_byte = r_frame[23:16];
      3'd3:    w_tx_byte = r_frame[15:8];
      3'd4:    w_tx_byte = r_frame[7:0];
      3'd5:    w_tx_byte = {r_crc, 1'b1};
      default: w_tx_byte = 8'hFF;
    endcase
  end

  always_ff @(posedge CLK50 or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:      if (CMD_START) w_state_next = S_CRC;
      S_CRC:       if (r_bit_cnt == 6'd39) w_state_next = S_TX;
      S_TX:        w_state_next = S_TX_WAIT;
      S_TX_WAIT:   if (BYTE_DONE) w_state_next = (r_byte_idx == 3'd5) ? S_POLL : S_TX;
      S_POLL:      w_state_next = S_POLL_WAIT;
      S_POLL_WAIT: if (BYTE_DONE) w_state_next = S_RD;
      S_RD:        w_state_next = S_SAMPLE;
      S_SAMPLE:    w_state_next = (w_resp_hit || w_poll_expired) ? S_FIN : S_POLL;
      S_FIN:       w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    W_STB   = (r_state == S_TX) || (r_state == S_POLL);
    W_DATA  = (r_state == S_TX) ? w_tx_byte : 8'hFF;
    R_STB   = (r_state == S_RD);
    BUSY    = (r_state != S_IDLE);
    DONE    = (r_state == S_FIN);
    TIMEOUT = (r_state == S_FIN) && r_timeout;
    RESP    = r_resp;
  end

  // Frame stays intact during CRC; bits are read by index so TX can reuse it.
  always_ff @(posedge CLK50 or negedge RST_N) begin
    if (!RST_N) begin
      r_frame    <= '0;
      r_crc      <= '0;
      r_bit_cnt  <= '0;
      r_byte_idx <= '0;
      r_poll_cnt <= '0;
      r_resp     <= 8'hFF;
      r_timeout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (CMD_START) begin
            r_frame    <= {2'b01, CMD_INDEX, CMD_ARG};
            r_crc      <= '0;
            r_bit_cnt  <= '0;
            r_byte_idx <= '0;
            r_poll_cnt <= '0;
            r_timeout  <= 1'b0;
          end
        end
        S_CRC: begin
          r_crc     <= {r_crc[5:0], 1'b0} ^ (w_crc_fb ? C_CRC_POLY : 7'h00);
          r_bit_cnt <= r_bit_cnt + 6'd1;
        end
        S_TX_WAIT: begin
          if (BYTE_DONE && (r_byte_idx != 3'd5)) begin
            r_byte_idx <= r_byte_idx + 3'd1;
          end
        end
        S_SAMPLE: begin
          if (w_resp_hit) begin
            r_resp <= R_DATA;
          end else begin
            r_poll_cnt <= w_poll_inc;
            if (w_poll_expired) begin
              r_resp    <= 8'hFF;
              r_timeout <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
